// File: rtl/mem_port_sequencer_pkg.sv
// Shared types and constants for the instruction/data memory port sequencer.
package mem_port_sequencer_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, DATA, COMMIT} seq_state_t;
  typedef enum logic [1:0] {NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2} data_op_t;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} mem_size_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    data_op_t    op;
    mem_size_t   size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } data_req_t;

endpackage

// File: rtl/mem_port_sequencer_if.sv
// Single-ported memory bus: request held stable until a ready cycle.
interface mem_port_sequencer_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  modport master (output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                  input  mem_rdata_i, mem_ready_i);
  modport slave  (input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                  output mem_rdata_i, mem_ready_i);
endinterface

// File: rtl/mem_port_sequencer_lsu_lane_align.sv
// Byte-lane steering: store byte enables/replication and load extract/extend.
module lsu_lane_align
  import mem_port_sequencer_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  mem_size_t   size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdataLanes,
  output logic [31:0] rdataExt
);

  logic [7:0]  rByte;
  logic [15:0] rHalf;

  always_comb begin
    case (addrLo)
      2'd0:    rByte = rdata[7:0];
      2'd1:    rByte = rdata[15:8];
      2'd2:    rByte = rdata[23:16];
      default: rByte = rdata[31:24];
    endcase
    rHalf = addrLo[1] ? rdata[31:16] : rdata[15:0];

    be         = 4'b1111;
    wdataLanes = wdata;
    rdataExt   = rdata;
    case (size)
      BYTE: begin
        be         = 4'b0001 << addrLo;
        wdataLanes = {4{wdata[7:0]}};
        rdataExt   = uns ? {24'b0, rByte} : {{24{rByte[7]}}, rByte};
      end
      HALF: begin
        be         = addrLo[1] ? 4'b1100 : 4'b0011;
        wdataLanes = {2{wdata[15:0]}};
        rdataExt   = uns ? {16'b0, rHalf} : {{16{rHalf[15]}}, rHalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_sequencer.sv
// Fetch / decode / data / commit sequencer over one shared variable-latency memory.
// Define ARB_TIMEOUT_EN to abort transfers after TIMEOUT_CYCLES wait cycles.
module mem_port_sequencer
  import mem_port_sequencer_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = mem_port_sequencer_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic [1:0]  data_op_i,
  input  logic [1:0]  data_size_i,
  input  logic        data_unsigned_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic        squash_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] load_data_o,
  output logic        advance_o,
  output logic        bus_err_o,
  mem_port_sequencer_if.master mem
);

  seq_state_t  state;
  logic [31:0] instrQ, loadQ;
  data_req_t   reqQ;
  logic [3:0]  beLanes;
  logic [31:0] wdataLanes, rdataExt;
  logic        noData, timeout, isStore;
  logic        unusedPc;

  assign unusedPc = ^pc_i[1:0];
  assign noData   = squash_i || (data_op_t'(data_op_i) == NONE);
  assign isStore  = (reqQ.op == STORE);

  lsu_lane_align uAlign (
    .addrLo     (reqQ.addr[1:0]),
    .size       (reqQ.size),
    .uns        (reqQ.uns),
    .wdata      (reqQ.wdata),
    .rdata      (mem.mem_rdata_i),
    .be         (beLanes),
    .wdataLanes (wdataLanes),
    .rdataExt   (rdataExt)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] waitCnt;
  logic             errQ;

  // Counter idles at zero outside FETCH/DATA, so it is clear on every entry.
  always_ff @(posedge clk) begin
    if (rst || !mem.mem_req_o) waitCnt <= '0;
    else if (!mem.mem_ready_i) waitCnt <= waitCnt + 1'b1;
  end

  assign timeout   = mem.mem_req_o && !mem.mem_ready_i &&
                     (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err_o = (state == COMMIT) && errQ;
`else
  localparam int unusedTimeout = TIMEOUT_CYCLES;
  assign timeout   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      instrQ <= NOP_INSTR;
      loadQ  <= '0;
      reqQ   <= '0;
`ifdef ARB_TIMEOUT_EN
      errQ   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (mem.mem_ready_i) begin
            instrQ <= mem.mem_rdata_i;
            state  <= DECODE;
          end else if (timeout) begin
            instrQ <= NOP_INSTR;
            loadQ  <= '0;
            state  <= COMMIT;
`ifdef ARB_TIMEOUT_EN
            errQ   <= 1'b1;
`endif
          end
        end
        DECODE: begin
          if (noData) begin
            state <= FETCH;
          end else begin
            reqQ  <= '{op: data_op_t'(data_op_i), size: mem_size_t'(data_size_i),
                       uns: data_unsigned_i, addr: data_addr_i, wdata: data_wdata_i};
            state <= DATA;
          end
        end
        DATA: begin
          if (mem.mem_ready_i) begin
            if (!isStore) loadQ <= rdataExt;
            state <= COMMIT;
          end else if (timeout) begin
            loadQ <= '0;
            state <= COMMIT;
`ifdef ARB_TIMEOUT_EN
            errQ  <= 1'b1;
`endif
          end
        end
        COMMIT: begin
          state <= FETCH;
`ifdef ARB_TIMEOUT_EN
          errQ  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fetch address follows the live PC, which the core updates on advance_o.
  assign mem.mem_req_o   = (state == FETCH) || (state == DATA);
  assign mem.mem_we_o    = (state == DATA) && isStore;
  assign mem.mem_be_o    = (state == FETCH) ? 4'b1111 : (state == DATA) ? beLanes : 4'b0000;
  assign mem.mem_addr_o  = (state == FETCH) ? {pc_i[31:2], 2'b00} :
                           (state == DATA)  ? {reqQ.addr[31:2], 2'b00} : 32'h0;
  assign mem.mem_wdata_o = mem.mem_we_o ? wdataLanes : 32'h0;

  assign instr_o       = instrQ;
  assign instr_valid_o = (state == DECODE) || (state == DATA) || (state == COMMIT);
  assign advance_o     = ((state == DECODE) && noData) || (state == COMMIT);
  assign load_data_o   = loadQ;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer with hand-computed expectations.
module tb_mem_port_sequencer;
  import mem_port_sequencer_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, data_addr_i, data_wdata_i, instr_o, load_data_o;
  logic [1:0]  data_op_i, data_size_i;
  logic        data_unsigned_i, squash_i, instr_valid_o, advance_o, bus_err_o;
  int          nVec = 0;
  int          nErr = 0;

  always #5 clk = ~clk;

  mem_port_sequencer_if bus ();

  mem_port_sequencer #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk (clk), .rst (rst), .pc_i (pc_i),
    .data_op_i (data_op_i), .data_size_i (data_size_i),
    .data_unsigned_i (data_unsigned_i), .data_addr_i (data_addr_i),
    .data_wdata_i (data_wdata_i), .squash_i (squash_i),
    .instr_o (instr_o), .instr_valid_o (instr_valid_o),
    .load_data_o (load_data_o), .advance_o (advance_o),
    .bus_err_o (bus_err_o), .mem (bus.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Starts at a negedge in FETCH, ends at a negedge in the next FETCH.
  task automatic runData(input string tag, input logic [31:0] pc, input logic [1:0] op,
                         input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rword,
                         input logic [3:0] expBe, input logic [31:0] expAddr,
                         input logic [31:0] expOut);
    pc_i = pc; bus.mem_rdata_i = 32'h0000_0003 | {pc[15:0], 16'h0}; bus.mem_ready_i = 1'b1;
    #1 chk({tag, ".fetchAddr"}, bus.mem_addr_o, {pc[31:2], 2'b00});
    cyc();
    data_op_i = op; data_size_i = size; data_unsigned_i = uns;
    data_addr_i = addr; data_wdata_i = wdata; bus.mem_rdata_i = rword;
    #1 chk({tag, ".decAdv"}, advance_o, 1'b0);
    chk({tag, ".decValid"}, instr_valid_o, 1'b1);
    cyc();
    data_op_i = NONE;
    #1 chk({tag, ".req"}, bus.mem_req_o, 1'b1);
    chk({tag, ".we"}, bus.mem_we_o, op == STORE);
    chk({tag, ".be"}, bus.mem_be_o, expBe);
    chk({tag, ".addr"}, bus.mem_addr_o, expAddr);
    if (op == STORE) chk({tag, ".wdata"}, bus.mem_wdata_o, expOut);
    cyc();
    bus.mem_ready_i = 1'b0;
    #1 chk({tag, ".commitAdv"}, advance_o, 1'b1);
    chk({tag, ".commitReq"}, bus.mem_req_o, 1'b0);
    chk({tag, ".busErr"}, bus_err_o, 1'b0);
    if (op == LOAD) chk({tag, ".load"}, load_data_o, expOut);
    cyc();
  endtask

  initial begin
    rst = 1'b1; pc_i = '0; data_op_i = NONE; data_size_i = WORD; data_unsigned_i = 1'b0;
    data_addr_i = '0; data_wdata_i = '0; squash_i = 1'b0;
    bus.mem_rdata_i = '0; bus.mem_ready_i = 1'b0;
    cyc(); cyc();
    #1 chk("rst.instr", instr_o, 32'h0000_0013);
    chk("rst.valid", instr_valid_o, 1'b0);
    chk("rst.req", bus.mem_req_o, 1'b0);
    chk("rst.adv", advance_o, 1'b0);
    chk("rst.be", bus.mem_be_o, 4'b0000);
    chk("rst.load", load_data_o, 32'h0);
    chk("rst.err", bus_err_o, 1'b0);
    rst = 1'b0;
    cyc();

    // addi at 0x8000_0004, zero-wait: advance in the cycle after the fetch
    pc_i = 32'h8000_0004; bus.mem_rdata_i = 32'h0010_0093; bus.mem_ready_i = 1'b1;
    #1 chk("addi.req", bus.mem_req_o, 1'b1);
    chk("addi.addr", bus.mem_addr_o, 32'h8000_0004);
    chk("addi.be", bus.mem_be_o, 4'b1111);
    chk("addi.we", bus.mem_we_o, 1'b0);
    chk("addi.adv0", advance_o, 1'b0);
    cyc();
    #1 chk("addi.instr", instr_o, 32'h0010_0093);
    chk("addi.adv", advance_o, 1'b1);
    chk("addi.idleReq", bus.mem_req_o, 1'b0);
    pc_i = 32'h8000_0008;
    cyc();
    #1 chk("addi.nextAddr", bus.mem_addr_o, 32'h8000_0008);
    chk("addi.nextReq", bus.mem_req_o, 1'b1);

    runData("lb",  32'h8000_0008, LOAD,  BYTE, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000,
            4'b1000, 32'h0000_1000, 32'hFFFF_FF80);
    runData("lbu", 32'h8000_000C, LOAD,  BYTE, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_0000,
            4'b1000, 32'h0000_1000, 32'h0000_0080);
    runData("sh",  32'h8000_0010, STORE, HALF, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h0,
            4'b1100, 32'h0000_2000, 32'hBEEF_BEEF);
    runData("lh",  32'h8000_0014, LOAD,  HALF, 1'b0, 32'h0000_3002, 32'h0, 32'h8001_1234,
            4'b1100, 32'h0000_3000, 32'hFFFF_8001);
    runData("lhu", 32'h8000_0018, LOAD,  HALF, 1'b1, 32'h0000_3000, 32'h0, 32'h8001_F234,
            4'b0011, 32'h0000_3000, 32'h0000_F234);
    runData("sb",  32'h8000_001C, STORE, BYTE, 1'b0, 32'h0000_4001, 32'h1234_56A5, 32'h0,
            4'b0010, 32'h0000_4000, 32'hA5A5_A5A5);
    runData("sw",  32'h8000_0020, STORE, WORD, 1'b0, 32'h0000_5000, 32'h1234_5678, 32'h0,
            4'b1111, 32'h0000_5000, 32'h1234_5678);
    runData("lw",  32'h8000_0024, LOAD,  WORD, 1'b0, 32'h0000_6000, 32'h0, 32'hCAFE_F00D,
            4'b1111, 32'h0000_6000, 32'hCAFE_F00D);

    // 3 wait cycles on fetch: address held 4 cycles, advance in the 5th
    pc_i = 32'h8000_0028; bus.mem_rdata_i = 32'h0020_0113;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready_i = (i == 3);
      #1 chk("wait.req", bus.mem_req_o, 1'b1);
      chk("wait.addr", bus.mem_addr_o, 32'h8000_0028);
      chk("wait.adv", advance_o, 1'b0);
      cyc();
    end
    bus.mem_ready_i = 1'b0;
    #1 chk("wait.advance", advance_o, 1'b1);
    chk("wait.instr", instr_o, 32'h0020_0113);
    pc_i = 32'h8000_002C;
    cyc();

    // squashed store: commit from DECODE, no data request
    bus.mem_rdata_i = 32'h0011_2023; bus.mem_ready_i = 1'b1;
    cyc();
    data_op_i = STORE; data_size_i = WORD; data_addr_i = 32'h0000_7000;
    data_wdata_i = 32'hDEAD_BEEF; squash_i = 1'b1;
    #1 chk("squash.adv", advance_o, 1'b1);
    chk("squash.we", bus.mem_we_o, 1'b0);
    chk("squash.req", bus.mem_req_o, 1'b0);
    pc_i = 32'h8000_0030;
    cyc();
    squash_i = 1'b0; data_op_i = NONE; bus.mem_ready_i = 1'b0;
    #1 chk("squash.nextWe", bus.mem_we_o, 1'b0);
    chk("squash.nextAddr", bus.mem_addr_o, 32'h8000_0030);

`ifdef ARB_TIMEOUT_EN
    // fetch never acknowledged: abort after 4 wait cycles
    for (int i = 0; i < 4; i++) begin
      #1 chk("to.req", bus.mem_req_o, 1'b1);
      chk("to.adv", advance_o, 1'b0);
      cyc();
    end
    #1 chk("to.busErr", bus_err_o, 1'b1);
    chk("to.advance", advance_o, 1'b1);
    chk("to.instr", instr_o, 32'h0000_0013);
    cyc();
    #1 chk("to.errClear", bus_err_o, 1'b0);
`endif

    // reset while in DATA abandons the transfer
    pc_i = 32'h8000_0034; bus.mem_rdata_i = 32'h0000_2083; bus.mem_ready_i = 1'b1;
    cyc();
    data_op_i = LOAD; data_size_i = WORD; data_addr_i = 32'h0000_8000;
    bus.mem_ready_i = 1'b0;
    cyc();
    data_op_i = NONE;
    #1 chk("rstData.req", bus.mem_req_o, 1'b1);
    rst = 1'b1;
    cyc();
    #1 chk("rstData.reqOff", bus.mem_req_o, 1'b0);
    chk("rstData.adv", advance_o, 1'b0);
    chk("rstData.valid", instr_valid_o, 1'b0);
    rst = 1'b0;
    cyc();
    #1 chk("rstData.refetch", bus.mem_req_o, 1'b1);
    chk("rstData.refAddr", bus.mem_addr_o, 32'h8000_0034);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
